// File: rtl/axi_ram_slave_if.sv
// AXI4 channel bundle for one slave port of the bus.
// Carries the AW, W, B, AR and R channels. The clock and reset stay as plain
// ports on the modules that use this interface.
//   slave  modport : the responder (address/data/ready-for-response inputs,
//                    ready/response/read-data outputs)
//   master modport : the requester, with the mirrored directions
interface axi_ram_slave_if #(
  parameter int ID_WIDTH = 4
);
  // write address channel
  logic [ID_WIDTH-1:0] S_AWID;
  logic [31:0]         S_AWADDR;
  logic [7:0]          S_AWLEN;
  logic [1:0]          S_AWBURST;
  logic                S_AWVALID;
  logic                S_AWREADY;
  // write data channel
  logic [31:0]         S_WDATA;
  logic [3:0]          S_WSTRB;
  logic                S_WLAST;
  logic                S_WVALID;
  logic                S_WREADY;
  // write response channel
  logic [ID_WIDTH-1:0] S_BID;
  logic [1:0]          S_BRESP;
  logic                S_BVALID;
  logic                S_BREADY;
  // read address channel
  logic [ID_WIDTH-1:0] S_ARID;
  logic [31:0]         S_ARADDR;
  logic [7:0]          S_ARLEN;
  logic [1:0]          S_ARBURST;
  logic                S_ARVALID;
  logic                S_ARREADY;
  // read data channel
  logic [ID_WIDTH-1:0] S_RID;
  logic [31:0]         S_RDATA;
  logic [1:0]          S_RRESP;
  logic                S_RLAST;
  logic                S_RVALID;
  logic                S_RREADY;

  modport slave (
    input  S_AWID, S_AWADDR, S_AWLEN, S_AWBURST, S_AWVALID,
    output S_AWREADY,
    input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    output S_WREADY,
    output S_BID, S_BRESP, S_BVALID,
    input  S_BREADY,
    input  S_ARID, S_ARADDR, S_ARLEN, S_ARBURST, S_ARVALID,
    output S_ARREADY,
    output S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    input  S_RREADY
  );

  modport master (
    output S_AWID, S_AWADDR, S_AWLEN, S_AWBURST, S_AWVALID,
    input  S_AWREADY,
    output S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    input  S_WREADY,
    input  S_BID, S_BRESP, S_BVALID,
    output S_BREADY,
    output S_ARID, S_ARADDR, S_ARLEN, S_ARBURST, S_ARVALID,
    input  S_ARREADY,
    input  S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    output S_RREADY
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 RAM responder: a 32-bit word-addressed memory behind one slave port.
// Supports FIXED/INCR/WRAP bursts up to 256 beats; the write and read
// channels are served by independent FSMs, so one write burst and one read
// burst may be in flight at the same time. IDs are echoed unchanged.
//   S_CLK  : clock
//   S_RSTN : asynchronous active-low reset (control state only; memory kept)
//   bus    : AXI4 slave channels (AW, W, B, AR, R)
module axi_ram_slave #(
  parameter int ID_WIDTH  = 4,
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input logic            S_CLK,
  input logic            S_RSTN,
  axi_ram_slave_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [ADDR_W-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  // Word index after one beat. WRAP keeps the low log2(LEN+1) bits cycling
  // inside the aligned window; an illegal WRAP length degrades to INCR.
  function automatic idx_t next_idx(idx_t idx, logic [7:0] len, logic [1:0] burst);
    idx_t mask;
    idx_t res;
    mask = idx_t'(len);
    res  = idx + idx_t'(1);
    if (burst == BURST_FIXED) begin
      res = idx;
    end else if (burst == BURST_WRAP &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      res = (idx & ~mask) | ((idx + idx_t'(1)) & mask);
    end
    return res;
  endfunction

  // Contents are set only at configuration; reset leaves them alone.
  logic [31:0] mem_q [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  // ---------------- write side ----------------
  w_state_e            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
  logic [7:0]          aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]          aw_burst_q, aw_burst_d;
  idx_t                w_idx_q, w_idx_d;
  logic                w_err_q, w_err_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                mem_we;

  // ---------------- read side ----------------
  r_state_e            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
  logic [7:0]          ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]          ar_burst_q, ar_burst_d;
  idx_t                r_idx_q, r_idx_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  idx_t ar_start;

  assign aw_hs    = bus.S_AWVALID & awready_q;
  assign w_hs     = bus.S_WVALID  & wready_q;
  assign b_hs     = bus.S_BREADY  & bvalid_q;
  assign ar_hs    = bus.S_ARVALID & arready_q;
  assign r_hs     = bus.S_RREADY  & rvalid_q;
  assign ar_start = bus.S_ARADDR[ADDR_W+1:2];

  // Byte offset and region bits are decoded upstream.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.S_AWADDR[31:ADDR_W+2], bus.S_AWADDR[1:0],
                              bus.S_ARADDR[31:ADDR_W+2], bus.S_ARADDR[1:0]};

  always_comb begin
    // NOTE: every next-state value takes its hold value first, so no branch leaves one unassigned and no latch is inferred.
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_burst_d = aw_burst_q;
    w_idx_d    = w_idx_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    mem_we     = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (aw_hs) begin
        aw_id_d    = bus.S_AWID;
        aw_len_d   = bus.S_AWLEN;
        aw_burst_d = bus.S_AWBURST;
        w_idx_d    = bus.S_AWADDR[ADDR_W+1:2];
        w_cnt_d    = '0;
        w_err_d    = (bus.S_AWBURST == BURST_RSVD);
        w_state_d  = W_DATA;
      end
      W_DATA: if (w_hs) begin
        mem_we = (aw_burst_q != BURST_RSVD);
        // WLAST must coincide exactly with the final counted beat.
        if (bus.S_WLAST != (w_cnt_q == aw_len_q)) w_err_d = 1'b1;
        if (w_cnt_q == aw_len_q) begin
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q + 8'd1;
          w_idx_d = next_idx(w_idx_q, aw_len_q, aw_burst_q);
        end
      end
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    // Ready/valid are registered from the next state, so they stay low
    // until the first clock edge after reset is released.
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_len_d   = ar_len_q;
    ar_burst_d = ar_burst_q;
    r_idx_d    = r_idx_q;
    r_cnt_d    = r_cnt_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        ar_id_d    = bus.S_ARID;
        ar_len_d   = bus.S_ARLEN;
        ar_burst_d = bus.S_ARBURST;
        r_cnt_d    = '0;
        rvalid_d   = 1'b1;
        rlast_d    = (bus.S_ARLEN == 8'd0);
        rdata_d    = (bus.S_ARBURST == BURST_RSVD) ? 32'h0 : mem_q[ar_start];
        rresp_d    = (bus.S_ARBURST == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
        // r_idx holds the address of the beat to be loaded next.
        r_idx_d    = next_idx(ar_start, bus.S_ARLEN, bus.S_ARBURST);
        r_state_d  = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d = r_cnt_q + 8'd1;
          rlast_d = ((r_cnt_q + 8'd1) == ar_len_q);
          rdata_d = (ar_burst_q == BURST_RSVD) ? 32'h0 : mem_q[r_idx_q];
          r_idx_d = next_idx(r_idx_q, ar_len_q, ar_burst_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge S_CLK or negedge S_RSTN) begin
    if (!S_RSTN) begin
      w_state_q <= W_IDLE;   aw_id_q  <= '0; aw_len_q <= '0; aw_burst_q <= '0;
      w_idx_q   <= '0;       w_cnt_q  <= '0; w_err_q  <= 1'b0;
      awready_q <= 1'b0;     wready_q <= 1'b0; bvalid_q <= 1'b0;
      r_state_q <= R_IDLE;   ar_id_q  <= '0; ar_len_q <= '0; ar_burst_q <= '0;
      r_idx_q   <= '0;       r_cnt_q  <= '0; arready_q <= 1'b0;
      rvalid_q  <= 1'b0;     rlast_q  <= 1'b0; rdata_q <= '0; rresp_q <= '0;
    end else begin
      w_state_q <= w_state_d; aw_id_q  <= aw_id_d;  aw_len_q <= aw_len_d; aw_burst_q <= aw_burst_d;
      w_idx_q   <= w_idx_d;   w_cnt_q  <= w_cnt_d;  w_err_q  <= w_err_d;
      awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      r_state_q <= r_state_d; ar_id_q  <= ar_id_d;  ar_len_q <= ar_len_d; ar_burst_q <= ar_burst_d;
      r_idx_q   <= r_idx_d;   r_cnt_q  <= r_cnt_d;  arready_q <= arready_d;
      rvalid_q  <= rvalid_d;  rlast_q  <= rlast_d;  rdata_q  <= rdata_d;  rresp_q <= rresp_d;
    end
  end

  // NOTE: the memory array has no reset branch; contents must survive S_RSTN and a reset port would block RAM inference.
  // A read sampled on the same edge sees the pre-write word.
  always_ff @(posedge S_CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.S_WSTRB[b]) mem_q[w_idx_q][8*b +: 8] <= bus.S_WDATA[8*b +: 8];
      end
    end
  end

  assign bus.S_AWREADY = awready_q;
  assign bus.S_WREADY  = wready_q;
  assign bus.S_BVALID  = bvalid_q;
  assign bus.S_BID     = aw_id_q;
  assign bus.S_BRESP   = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign bus.S_ARREADY = arready_q;
  assign bus.S_RVALID  = rvalid_q;
  assign bus.S_RID     = ar_id_q;
  assign bus.S_RDATA   = rdata_q;
  assign bus.S_RRESP   = rresp_q;
  assign bus.S_RLAST   = rlast_q;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave. A word array models the memory;
// per-beat addresses are computed from the burst rules with plain
// arithmetic, and responses are predicted from the burst type and WLAST use.
module tb_axi_ram_slave;
  localparam int IDW   = 4;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_ram_slave_if #(.ID_WIDTH(IDW)) bus();

  axi_ram_slave #(.ID_WIDTH(IDW), .ADDR_W(AW), .INIT_ZERO(1'b1)) dut (
    .S_CLK (clk),
    .S_RSTN(rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wdata_q [$];
  logic [3:0]  wstrb_q [$];

  // Word index of beat 'beat' of a burst, straight from the burst rules.
  function automatic int beat_idx(logic [31:0] addr, int len, logic [1:0] burst, int beat);
    int start, n, base;
    start = int'(addr >> 2) % DEPTH;
    n     = len + 1;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      base = start - (start % n);
      return base + ((start - base + beat) % n);
    end
    return (start + beat) % DEPTH;
  endfunction

  task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int early_last, input string name);
    int cyc;
    logic exp_err, last;
    int idx;
    exp_err = (burst == 2'b11);
    bus.S_AWID = id; bus.S_AWADDR = addr; bus.S_AWLEN = 8'(len); bus.S_AWBURST = burst;
    bus.S_AWVALID = 1'b1;
    cyc = 0;
    while (!bus.S_AWREADY && cyc < 50) begin @(posedge clk); #1; cyc++; end
    tests_run++;
    if (bus.S_AWREADY !== 1'b1) begin
      tests_failed++; $display("FAIL %s_aw_timeout: awready=%b want 1", name, bus.S_AWREADY);
      bus.S_AWVALID = 1'b0; return;
    end
    @(posedge clk); #1;
    bus.S_AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if ($urandom_range(0, 3) == 0) begin bus.S_WVALID = 1'b0; @(posedge clk); #1; end
      last = (early_last >= 0) ? (b == early_last) : (b == len);
      if (last != (b == len)) exp_err = 1'b1;
      bus.S_WDATA = wdata_q[b]; bus.S_WSTRB = wstrb_q[b]; bus.S_WLAST = last; bus.S_WVALID = 1'b1;
      cyc = 0;
      while (!bus.S_WREADY && cyc < 50) begin @(posedge clk); #1; cyc++; end
      tests_run++;
      if (bus.S_WREADY !== 1'b1) begin
        tests_failed++; $display("FAIL %s_w_timeout beat %0d: wready=%b want 1", name, b, bus.S_WREADY);
        bus.S_WVALID = 1'b0; return;
      end
      @(posedge clk); #1;
      if (burst != 2'b11) begin
        idx = beat_idx(addr, len, burst, b);
        for (int l = 0; l < 4; l++)
          if (wstrb_q[b][l]) model_mem[idx][8*l +: 8] = wdata_q[b][8*l +: 8];
      end
    end
    bus.S_WVALID = 1'b0; bus.S_WLAST = 1'b0;
    cyc = 0;
    while (!bus.S_BVALID && cyc < 50) begin @(posedge clk); #1; cyc++; end
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    tests_run++;
    if (bus.S_BVALID !== 1'b1 || bus.S_BID !== id || bus.S_BRESP !== (exp_err ? 2'b10 : 2'b00)) begin
      tests_failed++;
      $display("FAIL %s_bresp: bvalid=%b bid=%0d bresp=%b, want bvalid=1 bid=%0d bresp=%b",
               name, bus.S_BVALID, bus.S_BID, bus.S_BRESP, id, exp_err ? 2'b10 : 2'b00);
    end
    bus.S_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_BREADY = 1'b0;
    tests_run++;
    if (bus.S_BVALID !== 1'b0) begin
      tests_failed++; $display("FAIL %s_bvalid_drop: bvalid=%b want 0", name, bus.S_BVALID);
    end
  endtask

  // mode 0: RREADY always high (and no gaps allowed), 1: toggling, 2: random
  task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int mode, input string name);
    int cyc, beat, gaps;
    logic rr, held_v;
    logic [31:0] held, exp_data;
    logic [1:0] exp_resp;
    bus.S_ARID = id; bus.S_ARADDR = addr; bus.S_ARLEN = 8'(len); bus.S_ARBURST = burst;
    bus.S_ARVALID = 1'b1;
    cyc = 0;
    while (!bus.S_ARREADY && cyc < 50) begin @(posedge clk); #1; cyc++; end
    tests_run++;
    if (bus.S_ARREADY !== 1'b1) begin
      tests_failed++; $display("FAIL %s_ar_timeout: arready=%b want 1", name, bus.S_ARREADY);
      bus.S_ARVALID = 1'b0; return;
    end
    @(posedge clk); #1;
    bus.S_ARVALID = 1'b0;
    beat = 0; gaps = 0; cyc = 0; held_v = 1'b0; held = '0;
    exp_resp = (burst == 2'b11) ? 2'b10 : 2'b00;
    while (beat <= len && cyc < 3000) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = cyc[0];
        default: rr = 1'($urandom_range(0, 1));
      endcase
      bus.S_RREADY = rr;
      if (bus.S_RVALID === 1'b1) begin
        if (held_v) begin
          tests_run++;
          if (bus.S_RDATA !== held) begin
            tests_failed++; $display("FAIL %s_stall_hold beat %0d: rdata=%h want %h", name, beat, bus.S_RDATA, held);
          end
        end
        if (rr) begin
          exp_data = (burst == 2'b11) ? 32'h0 : model_mem[beat_idx(addr, len, burst, beat)];
          tests_run++;
          if (bus.S_RDATA !== exp_data || bus.S_RID !== id || bus.S_RRESP !== exp_resp ||
              bus.S_RLAST !== (beat == len)) begin
            tests_failed++;
            $display("FAIL %s_beat %0d: rdata=%h rid=%0d rresp=%b rlast=%b, want rdata=%h rid=%0d rresp=%b rlast=%b",
                     name, beat, bus.S_RDATA, bus.S_RID, bus.S_RRESP, bus.S_RLAST,
                     exp_data, id, exp_resp, (beat == len));
          end
          beat++; held_v = 1'b0;
        end else begin
          held = bus.S_RDATA; held_v = 1'b1;
        end
      end else begin
        gaps++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.S_RREADY = 1'b0;
    tests_run++;
    if (beat <= len) begin
      tests_failed++; $display("FAIL %s_r_timeout: got %0d beats want %0d", name, beat, len + 1);
    end
    if (mode == 0) begin
      tests_run++;
      if (gaps != 0) begin
        tests_failed++; $display("FAIL %s_back_to_back: %0d idle cycles want 0", name, gaps);
      end
    end
    tests_run++;
    if (bus.S_RVALID !== 1'b0) begin
      tests_failed++; $display("FAIL %s_rvalid_drop: rvalid=%b want 0", name, bus.S_RVALID);
    end
  endtask

  task automatic fill(input int n);
    wdata_q.delete(); wstrb_q.delete();
    for (int i = 0; i < n; i++) begin wdata_q.push_back($urandom()); wstrb_q.push_back(4'hF); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_ARREADY, bus.S_RVALID, bus.S_RLAST} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: aw/w/b/ar/rv/rl=%b want 000000",
               {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_ARREADY, bus.S_RVALID, bus.S_RLAST});
    end
    tests_run++;
    if ({bus.S_RDATA, bus.S_RID, bus.S_RRESP, bus.S_BID, bus.S_BRESP} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata=%h rid=%0d rresp=%b bid=%0d bresp=%b want all 0",
               bus.S_RDATA, bus.S_RID, bus.S_RRESP, bus.S_BID, bus.S_BRESP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.S_AWREADY !== 1'b0 || bus.S_ARREADY !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ready_early: awready=%b arready=%b want 0 0", bus.S_AWREADY, bus.S_ARREADY);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.S_AWREADY !== 1'b1 || bus.S_ARREADY !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready_rise: awready=%b arready=%b want 1 1", bus.S_AWREADY, bus.S_ARREADY);
    end
  endtask

  task automatic test_single();
    wdata_q = '{32'hDEADBEEF}; wstrb_q = '{4'hF};
    do_write(4'd3, 32'h10, 0, 2'b01, -1, "single_wr");
    do_read(4'd3, 32'h10, 0, 2'b01, 0, "single_rd");
  endtask

  task automatic test_incr_wrap();
    wdata_q = '{32'h11, 32'h22, 32'h33, 32'h44}; wstrb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'd1, 32'h100, 3, 2'b01, -1, "incr_wr");
    do_read(4'd2, 32'h100, 3, 2'b01, 0, "incr_rd");
    do_read(4'd4, 32'h108, 3, 2'b10, 0, "wrap_rd");
  endtask

  task automatic test_strobe();
    wdata_q = '{32'hAABBCCDD}; wstrb_q = '{4'b0101};
    do_write(4'd6, 32'h300, 0, 2'b01, -1, "strobe_wr");
    do_read(4'd6, 32'h300, 0, 2'b01, 1, "strobe_rd");
    fill(6);
    do_write(4'd6, 32'h310, 5, 2'b01, -1, "stall_wr");
    do_read(4'd7, 32'h310, 5, 2'b01, 1, "stall_rd");
  endtask

  task automatic test_errors();
    fill(4);
    do_write(4'd9, 32'h180, 3, 2'b01, 1, "early_wlast_wr");
    do_read(4'd9, 32'h180, 3, 2'b01, 2, "early_wlast_rd");
    fill(2);
    do_write(4'd10, 32'h180, 1, 2'b11, -1, "rsvd_wr");
    do_read(4'd10, 32'h180, 1, 2'b11, 0, "rsvd_rd");
    do_read(4'd11, 32'h180, 3, 2'b01, 0, "rsvd_untouched_rd");
  endtask

  task automatic test_concurrent();
    fill(8);
    fork
      do_write(4'd12, 32'h200, 7, 2'b01, -1, "conc_wr");
      do_read(4'd13, 32'h100, 3, 2'b01, 2, "conc_rd");
    join
    do_read(4'd12, 32'h200, 7, 2'b01, 0, "conc_check_rd");
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int len;
      logic [1:0] burst;
      logic [31:0] addr;
      len   = $urandom_range(0, 15);
      burst = 2'($urandom_range(0, 2));
      addr  = $urandom();
      wdata_q.delete(); wstrb_q.delete();
      for (int i = 0; i <= len; i++) begin
        wdata_q.push_back($urandom()); wstrb_q.push_back(4'($urandom_range(0, 15)));
      end
      do_write(4'($urandom_range(0, 15)), addr, len, burst, -1, "rand_wr");
      do_read(4'($urandom_range(0, 15)), addr, len, burst, 2, "rand_rd");
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    bus.S_ARID = 4'd5; bus.S_ARADDR = 32'h100; bus.S_ARLEN = 8'd7; bus.S_ARBURST = 2'b01;
    bus.S_ARVALID = 1'b1; bus.S_RREADY = 1'b0;
    cyc = 0;
    while (!bus.S_ARREADY && cyc < 50) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    bus.S_ARVALID = 1'b0;
    bus.S_RREADY = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.S_RREADY = 1'b0;
    tests_run++;
    if (bus.S_RVALID !== 1'b1 || bus.S_RLAST !== 1'b0) begin
      tests_failed++; $display("FAIL midburst_active: rvalid=%b rlast=%b want 1 0", bus.S_RVALID, bus.S_RLAST);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.S_RVALID !== 1'b0 || bus.S_ARREADY !== 1'b0 || bus.S_AWREADY !== 1'b0) begin
      tests_failed++;
      $display("FAIL midburst_async_reset: rvalid=%b arready=%b awready=%b want 0 0 0",
               bus.S_RVALID, bus.S_ARREADY, bus.S_AWREADY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.S_ARREADY !== 1'b1 || bus.S_RVALID !== 1'b0) begin
      tests_failed++; $display("FAIL midburst_recover: arready=%b rvalid=%b want 1 0", bus.S_ARREADY, bus.S_RVALID);
    end
    do_read(4'd5, 32'h100, 3, 2'b01, 0, "post_reset_rd");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    bus.S_AWID = '0; bus.S_AWADDR = '0; bus.S_AWLEN = '0; bus.S_AWBURST = '0; bus.S_AWVALID = 1'b0;
    bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WLAST = 1'b0; bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0;
    bus.S_ARID = '0; bus.S_ARADDR = '0; bus.S_ARLEN = '0; bus.S_ARBURST = '0; bus.S_ARVALID = 1'b0;
    bus.S_RREADY = 1'b0;
    test_reset();
    test_single();
    test_incr_wrap();
    test_strobe();
    test_errors();
    test_concurrent();
    test_random();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- AXI4 responder endpoint that plugs into one slave port of the AXI bus; it is the far end of the masters' transactions.
- Backs an on-chip word-addressed memory and supports FIXED, INCR and WRAP bursts of up to 256 beats.
- Write and read channels run independently, so one write burst and one read burst can be in flight concurrently.
- Echoes the bus-extended ID unchanged.

Parameters:
ID_WIDTH, 4, AXI ID width (master ID plus master-select bits added by the interconnect).
ADDR_W, 10, word-address bits; memory depth is 2**ADDR_W words of 32 bits.
INIT_ZERO, 1, when 1 the memory contents are zero at configuration; no reset clear.

Ports:
Each line groups one AXI channel's signals under a shared direction. Widths are given in the same order as the signal names.
S_CLK  input  1  slave clock.
S_RSTN  input  1  asynchronous active-low reset.
S_AWID/S_AWADDR/S_AWLEN/S_AWBURST/S_AWVALID  input  ID_WIDTH/32/8/2/1  write address channel.
S_AWREADY  output  1  write address accept.
S_WDATA/S_WSTRB/S_WLAST/S_WVALID  input  32/4/1/1  write data channel.
S_WREADY  output  1  write data accept.
S_BID/S_BRESP/S_BVALID  output  ID_WIDTH/2/1  write response.
S_BREADY  input  1  write response accept.
S_ARID/S_ARADDR/S_ARLEN/S_ARBURST/S_ARVALID  input  ID_WIDTH/32/8/2/1  read address channel.
S_ARREADY  output  1  read address accept.
S_RID/S_RDATA/S_RRESP/S_RLAST/S_RVALID  output  ID_WIDTH/32/2/1/1  read data channel.
S_RREADY  input  1  read data accept.

Behaviour:
- One clock, S_CLK. S_RSTN is asynchronous and active-low.
- Reset values: all outputs 0, both FSMs in IDLE, beat counters 0.
  - AWREADY and ARREADY rise on the first S_CLK edge after S_RSTN deasserts.
  - A reset mid-burst abandons the burst; memory contents are kept.
- Word index: ADDR[ADDR_W+1:2]. ADDR[1:0] and upper address bits are ignored (the bus already decodes the region). The index wraps modulo 2**ADDR_W.
- Next-address rule, applied after each beat:
  - FIXED (00): address unchanged.
  - INCR (01): address +1 word.
  - WRAP (10): wraps inside an aligned (LEN+1)-word window. LEN must be 1, 3, 7 or 15; any other LEN is treated as INCR.
  - 11 (reserved): error burst.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID, address, LEN and BURST; clear the beat counter and the error flag; go to W_DATA. AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes WDATA into the memory byte lanes enabled by WSTRB, then increments the counter.
  - WLAST asserted on a beat with counter != LEN, or deasserted on the beat with counter == LEN, sets the error flag.
  - The burst ends on counter == LEN regardless of WLAST; go to W_RESP.
  - For BURST=11 no writes occur and the error flag is set.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=10 (SLVERR) if the error flag is set, else 00. Hold until BREADY, then go to W_IDLE.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On the handshake, latch the fields and go to R_DATA.
  - First beat: RVALID and RDATA=mem[addr] appear the next cycle.
  - On each RVALID&RREADY that is not the last beat, RDATA is reloaded from the next address in the same edge. This gives one beat per cycle back-to-back.
  - RDATA, RID, RRESP and RLAST are held while RREADY=0.
  - RLAST=1 on beat LEN. After its handshake, RVALID=0 and the FSM returns to R_IDLE; a new AR can be accepted that same cycle.
  - BURST=11: RDATA=0 and RRESP=10 on all LEN+1 beats. Otherwise RRESP=00.
- Memory collisions:
  - A read sample and a write to the same word on the same edge return old data.
  - A write lands before any read sampled on a later edge.

Test Plan:
- Single write AW(ID=3, ADDR=0x10, LEN=0, INCR), W(0xDEADBEEF, STRB=F, WLAST=1) -> BID=3, BRESP=00. Then AR at 0x10 -> RDATA=0xDEADBEEF, RLAST=1, RID=3.
- INCR write of 4 beats to 0x100 (0x11, 0x22, 0x33, 0x44), then INCR read with LEN=3 and RREADY held high -> 4 consecutive-cycle beats 0x11..0x44, RLAST on the 4th only.
- WRAP read LEN=3 starting at 0x108 over data 0x11..0x44 at 0x100..0x10C -> beats 0x33, 0x44, 0x11, 0x22.
- Partial strobe: write 0xAABBCCDD with STRB=0101 over existing 0x00000000 -> readback 0x00BB00DD. RREADY toggled every other cycle -> RDATA stable while stalled.
- Early WLAST on beat 1 of a LEN=3 burst -> all 4 beats still accepted, BRESP=10. BURST=11 read LEN=1 -> two beats with RDATA=0, RRESP=10.
- Concurrent write burst and read burst, plus S_RSTN pulsed mid read burst -> RVALID=0 asynchronously. Read address 0x100 again after reset -> previously written data intact.
